fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  F stage of the 5-stage MIPS pipeline; supplies the decode stage with the data it consumes.
//  Holds the PC, drives the instruction-memory address, and checks fetch addresses (AdEL).
//  Owns the F/D pipeline register: instr_D, PC_D, ExcCode_D, bd_D.
//  Redirects on branch/jump target from D, CP0 exception entry, and eret.
// PARAMETERS
//  RESET_PC      32'h0000_3000  PC value after reset
//  EXC_ENTRY     32'h0000_4180  handler address loaded on exc_req
//  IM_BASE       32'h0000_3000  lowest legal fetch address
//  IM_WORDS      4096           IM size in words; legal range is [IM_BASE, IM_BASE+4*IM_WORDS)
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   synchronous, active-high
//  stall      in   1   hazard unit: hold PC and F/D register
//  npc        in   32  next PC computed by decode stage
//  npc_take   in   1   D holds taken branch/jump: next PC = npc
//  is_jb_D    in   1   instr currently in D is a branch/jump (marks next fetch as delay slot)
//  exc_req    in   1   CP0 takes exception/interrupt this cycle
//  eret_req   in   1   eret committing this cycle
//  epc        in   32  return address for eret
//  imem_rdata in   32  instruction word at pc_F (combinational IM)
//  pc_F       out  32  current fetch address to IM
//  instr_D    out  32  instruction register to D
//  PC_D       out  32  PC of instr_D
//  ExcCode_D  out  5   fetch exception code (0 = none, 4 = AdEL)
//  bd_D       out  1   instr_D is in a branch delay slot
// BEHAVIOUR
//  Reset (sync, highest priority): pc_F=RESET_PC, instr_D=0, PC_D=RESET_PC, ExcCode_D=0, bd_D=0.
//  fetch_err = (pc_F[1:0]!=0) | (pc_F<IM_BASE) | (pc_F>=IM_BASE+4*IM_WORDS); combinational.
//  PC update priority per cycle: reset > exc_req > eret_req > stall > npc_take > pc_F+4.
//   exc_req : pc_F<=EXC_ENTRY; F/D flushed.
//   eret_req: pc_F<=epc; F/D flushed (eret has no delay slot).
//   stall   : pc_F and the entire F/D register hold their values; npc_take is ignored.
//   npc_take: pc_F<=npc. The instruction fetched in this same cycle is the delay slot
//             and still enters D normally.
//   else    : pc_F<=pc_F+4, with modulo-2^32 wrap and no overflow check.
//  F/D load when not reset/flush/stall:
//   instr_D<=fetch_err?0:imem_rdata; PC_D<=pc_F; ExcCode_D<=fetch_err?5'd4:0; bd_D<=is_jb_D.
//  Flush loads a bubble: instr_D=0 (nop), ExcCode_D=0, bd_D=0, PC_D<=pc_F.
//   This gives CP0 a valid EPC candidate for the bubble.
//  exc_req together with stall: the flush and redirect win and the stall is dropped.
//  exc_req together with eret_req: exc_req wins.
//  A misaligned or out-of-range npc/epc is accepted into pc_F and reported as AdEL.
//   The AdEL appears on ExcCode_D when that PC advances to D. imem_rdata is never forwarded on error.
//  Latency: a redirect takes effect on pc_F in the next cycle. instr_D lags pc_F by 1 cycle.
//  No combinational path from any input to pc_F; all outputs are registered.
// TESTING
//  Reset for 2 cycles, then free-run 3 cycles -> pc_F 3000,3004,3008,300C; PC_D 3000,3000,3004,3008.
//  npc_take=1, npc=3040, is_jb_D=1 at pc_F=3008 -> next pc_F=3040; instr at 3008 enters D with bd_D=1.
//  stall=1 for 3 cycles with npc_take=1 -> pc_F, instr_D, PC_D unchanged; resume with stall=0 -> normal flow.
//  exc_req=1 together with stall=1 at pc_F=3010 -> pc_F=4180, instr_D=0, ExcCode_D=0, bd_D=0.
//  eret_req=1, epc=3002 -> pc_F=3002, then ExcCode_D=4, instr_D=0, PC_D=3002; same result for epc=2FFC.
//  Reset asserted mid-stream with exc_req=1 -> pc_F=3000 and all D outputs at reset values.

Source files
------------

// File: rtl/fetch_stage.sv
// Fetch stage of the 5-stage MIPS pipeline.
// Holds the fetch PC, flags illegal fetch addresses (AdEL), and owns the F/D
// pipeline register consumed by decode. Redirects come from decode
// (branch/jump), from CP0 exception entry and from eret.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter int unsigned IM_WORDS  = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic [31:0] npc,
    input  logic        npc_take,
    input  logic        is_jb_D,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc_F,
    output logic [31:0] instr_D,
    output logic [31:0] PC_D,
    output logic [4:0]  ExcCode_D,
    output logic        bd_D
);

    localparam logic [4:0]  EXC_ADEL = 5'd4;
    localparam logic [4:0]  EXC_NONE = 5'd0;
    localparam logic [32:0] IM_END   = {1'b0, IM_BASE} + 33'(4 * IM_WORDS);

    logic fetch_err;
    logic flush;

    // Address check on the current fetch PC; the comparison is done in 33 bits
    // so an IM window ending exactly at 2^32 does not wrap to zero.
    always_comb begin
        fetch_err = 1'b0;
        flush     = exc_req | eret_req;
        if ((pc_F[1:0] != 2'b00) ||
            (pc_F < IM_BASE) ||
            ({1'b0, pc_F} >= IM_END)) begin
            fetch_err = 1'b1;
        end
    end

    // PC and F/D register: reset beats exception beats eret beats stall; a
    // flush inserts a nop bubble whose PC_D still gives CP0 a usable EPC.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_F      <= RESET_PC;
            instr_D   <= 32'd0;
            PC_D      <= RESET_PC;
            ExcCode_D <= EXC_NONE;
            bd_D      <= 1'b0;
        end else if (flush) begin
            pc_F      <= exc_req ? EXC_ENTRY : epc;
            instr_D   <= 32'd0;
            PC_D      <= pc_F;
            ExcCode_D <= EXC_NONE;
            bd_D      <= 1'b0;
        end else if (!stall) begin
            pc_F      <= npc_take ? npc : (pc_F + 32'd4);
            instr_D   <= fetch_err ? 32'd0 : imem_rdata;
            PC_D      <= pc_F;
            ExcCode_D <= fetch_err ? EXC_ADEL : EXC_NONE;
            bd_D      <= is_jb_D;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios followed by a
// randomized run, all compared against a cycle-level behavioural model.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [31:0] npc;
    logic        npc_take;
    logic        is_jb_D;
    logic        exc_req;
    logic        eret_req;
    logic [31:0] epc;
    logic [31:0] imem_rdata;
    logic [31:0] pc_F;
    logic [31:0] instr_D;
    logic [31:0] PC_D;
    logic [4:0]  ExcCode_D;
    logic        bd_D;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic [4:0]  m_exc;
    logic        m_bd;

    fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .npc        (npc),
        .npc_take   (npc_take),
        .is_jb_D    (is_jb_D),
        .exc_req    (exc_req),
        .eret_req   (eret_req),
        .epc        (epc),
        .imem_rdata (imem_rdata),
        .pc_F       (pc_F),
        .instr_D    (instr_D),
        .PC_D       (PC_D),
        .ExcCode_D  (ExcCode_D),
        .bd_D       (bd_D)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction memory contents: a scrambled, address-dependent word.
    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'hC0FF_EE11;
    endfunction

    // Combinational instruction memory looking at the DUT fetch address.
    assign imem_rdata = mem_word(pc_F);

    function automatic logic bad_addr(input logic [31:0] addr);
        longint unsigned a;
        a = longint'(addr);
        return (a % 4 != 0) || (a < 64'h3000) || (a >= 64'h3000 + 4 * 4096);
    endfunction

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, ".pc_F"},      pc_F,              m_pc);
        checkValue({tag, ".instr_D"},   instr_D,           m_instr);
        checkValue({tag, ".PC_D"},      PC_D,              m_pcd);
        checkValue({tag, ".ExcCode_D"}, {27'd0, ExcCode_D}, {27'd0, m_exc});
        checkValue({tag, ".bd_D"},      {31'd0, bd_D},     {31'd0, m_bd});
    endtask

    // Drives one cycle of inputs, advances the model by the same cycle, and
    // leaves time just after the edge so outputs can be sampled.
    task automatic applyStimulus(input logic rst, input logic st, input logic nt,
                                 input logic [31:0] n, input logic jb, input logic ex,
                                 input logic er, input logic [31:0] ep);
        logic [31:0] nx_pc;
        logic [31:0] nx_instr;
        logic [31:0] nx_pcd;
        logic [4:0]  nx_exc;
        logic        nx_bd;
        reset    = rst;
        stall    = st;
        npc_take = nt;
        npc      = n;
        is_jb_D  = jb;
        exc_req  = ex;
        eret_req = er;
        epc      = ep;
        nx_pc = m_pc; nx_instr = m_instr; nx_pcd = m_pcd; nx_exc = m_exc; nx_bd = m_bd;
        if (rst) begin
            nx_pc = 32'h3000; nx_instr = 0; nx_pcd = 32'h3000; nx_exc = 0; nx_bd = 0;
        end else if (ex || er) begin
            nx_pcd = m_pc;
            nx_pc = ex ? 32'h4180 : ep;
            nx_instr = 0; nx_exc = 0; nx_bd = 0;
        end else if (!st) begin
            nx_instr = bad_addr(m_pc) ? 32'd0 : mem_word(m_pc);
            nx_exc   = bad_addr(m_pc) ? 5'd4 : 5'd0;
            nx_pcd   = m_pc;
            nx_bd    = jb;
            nx_pc    = nt ? n : m_pc + 32'd4;
        end
        @(posedge clk);
        m_pc = nx_pc; m_instr = nx_instr; m_pcd = nx_pcd; m_exc = nx_exc; m_bd = nx_bd;
        #1;
    endtask

    // Directed scenarios, then randomized traffic, then a mid-stream reset.
    initial begin
        logic [31:0] pc_before;
        logic [31:0] instr_before;
        logic [31:0] pcd_before;
        m_pc = 0; m_instr = 0; m_pcd = 0; m_exc = 0; m_bd = 0;
        reset = 1; stall = 0; npc = 0; npc_take = 0; is_jb_D = 0;
        exc_req = 0; eret_req = 0; epc = 0;

        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset");
        checkValue("reset.pc_const", pc_F, 32'h3000);
        checkValue("reset.pcd_const", PC_D, 32'h3000);

        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("run1");
        checkValue("run1.pcd_const", PC_D, 32'h3000);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("run2");
        checkValue("run2.pc_const", pc_F, 32'h3008);

        applyStimulus(0, 0, 1, 32'h3040, 1, 0, 0, 0);
        checkOutput("branch");
        checkValue("branch.pc_const", pc_F, 32'h3040);
        checkValue("branch.bd_const", {31'd0, bd_D}, 32'd1);
        checkValue("branch.instr_const", instr_D, mem_word(32'h3008));

        pc_before = pc_F; instr_before = instr_D; pcd_before = PC_D;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 1, 32'h3100, 0, 0, 0, 0);
            checkOutput("stall");
            checkValue("stall.pc_hold", pc_F, pc_before);
            checkValue("stall.instr_hold", instr_D, instr_before);
            checkValue("stall.pcd_hold", PC_D, pcd_before);
        end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput("resume");
        end

        applyStimulus(0, 1, 0, 0, 0, 1, 0, 0);
        checkOutput("exc_stall");
        checkValue("exc_stall.pc_const", pc_F, 32'h4180);
        checkValue("exc_stall.instr_const", instr_D, 32'd0);

        applyStimulus(0, 0, 0, 0, 0, 1, 1, 32'h3010);
        checkOutput("exc_eret");
        checkValue("exc_eret.pc_const", pc_F, 32'h4180);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h3002);
        checkOutput("eret_mis");
        checkValue("eret_mis.pc_const", pc_F, 32'h3002);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("adel_mis");
        checkValue("adel_mis.exc_const", {27'd0, ExcCode_D}, 32'd4);
        checkValue("adel_mis.pcd_const", PC_D, 32'h3002);

        applyStimulus(0, 0, 0, 0, 0, 0, 1, 32'h2FFC);
        checkOutput("eret_low");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("adel_low");
        checkValue("adel_low.exc_const", {27'd0, ExcCode_D}, 32'd4);
        checkValue("adel_low.instr_const", instr_D, 32'd0);

        applyStimulus(0, 0, 1, 32'h6FFC, 0, 0, 0, 0);
        checkOutput("top_jump");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("top_word");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("past_top");
        checkValue("past_top.exc_const", {27'd0, ExcCode_D}, 32'd4);

        applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0);
        checkOutput("wrap_jump");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wrap");
        checkValue("wrap.pc_const", pc_F, 32'd0);

        for (int i = 0; i < 400; i++) begin
            logic [31:0] rn;
            logic [31:0] re;
            rn = ($urandom_range(0, 7) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 4095) << 2);
            re = ($urandom_range(0, 5) == 0) ? $urandom : 32'h3000 + ($urandom_range(0, 4095) << 2);
            applyStimulus(0,
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 3) == 0),
                          rn,
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 15) == 0),
                          1'($urandom_range(0, 15) == 0),
                          re);
            checkOutput("random");
        end

        applyStimulus(1, 0, 0, 0, 0, 1, 0, 0);
        checkOutput("reset_mid");
        checkValue("reset_mid.pc_const", pc_F, 32'h3000);
        checkValue("reset_mid.instr_const", instr_D, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
